// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential 8-bit binary to 3-digit BCD converter for a
// 7-segment display. Uses double-dabble, one iteration per clock. The input
// can be read as unsigned or as two's complement. Leading zeros can be blanked.
module bin_to_bcd_seq #(
    parameter bit         LZ_BLANK   = 1'b1,
    parameter logic [3:0] BLANK_CODE = 4'hF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] bin_in,
    input  logic       signed_mode,
    output logic       busy,
    output logic       done,
    output logic [3:0] dig_hund,
    output logic [3:0] dig_tens,
    output logic [3:0] dig_ones,
    output logic       neg
);

    // Reset value of the two upper digits: blank when leading zeros are suppressed.
    localparam logic [3:0] UPPER_RST = LZ_BLANK ? BLANK_CODE : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t      state;
    logic [3:0]  iter_cnt;
    logic [19:0] shreg;       // {hundreds, tens, ones, binary}
    logic [19:0] shreg_next;
    logic        sign;
    logic [7:0]  magnitude;

    // The two's-complement negation wraps within 8 bits, so 8'h80 becomes 128.
    assign magnitude = (signed_mode && bin_in[7]) ? (~bin_in + 8'd1) : bin_in;

    // Build one double-dabble step: add 3 to each BCD field >= 5, then shift left.
    always_comb begin
        // NOTE: combinational logic uses blocking '=' and assigns a default
        // first, so every path gives a value and no latch is inferred.
        shreg_next = shreg;
        if (shreg_next[19:16] >= 4'd5) shreg_next[19:16] = shreg_next[19:16] + 4'd3;
        if (shreg_next[15:12] >= 4'd5) shreg_next[15:12] = shreg_next[15:12] + 4'd3;
        if (shreg_next[11:8]  >= 4'd5) shreg_next[11:8]  = shreg_next[11:8]  + 4'd3;
        shreg_next = shreg_next << 1;
    end

    // Control FSM, datapath and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking '<=' only. Then every
        // register samples values from before the edge.
        if (!reset) begin
            state    <= IDLE;
            iter_cnt <= 4'd0;
            shreg    <= 20'd0;
            sign     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            neg      <= 1'b0;
            dig_ones <= 4'd0;
            dig_tens <= UPPER_RST;
            dig_hund <= UPPER_RST;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg    <= {12'd0, magnitude};
                        sign     <= signed_mode & bin_in[7];
                        iter_cnt <= 4'd0;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg    <= shreg_next;
                    iter_cnt <= iter_cnt + 4'd1;
                    if (iter_cnt == 4'd7) state <= DONE;
                end
                DONE: begin
                    // Hundreds blank when zero; tens blank only if hundreds also zero.
                    dig_hund <= (LZ_BLANK && shreg[19:16] == 4'd0) ? BLANK_CODE : shreg[19:16];
                    dig_tens <= (LZ_BLANK && shreg[19:12] == 8'd0) ? BLANK_CODE : shreg[15:12];
                    dig_ones <= shreg[11:8];
                    neg      <= sign && (shreg[19:8] != 12'd0);
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/bin_to_bcd_seq.md
BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 Parameter LZ_BLANK, default 1: when 1, leading-zero digits are replaced by BLANK_CODE; when 0, they are output as 0.
REQ-002 Parameter BLANK_CODE, default 4'hF: 4-bit code the downstream 7-segment decoder renders as an unlit digit.
REQ-003 clk  input  1  single system clock; all state changes occur on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 forces the reset state immediately, independent of clk.
REQ-005 start  input  1  request to convert bin_in; sampled on the rising clk edge.
REQ-006 bin_in  input  8  binary value to convert; captured only when start is accepted.
REQ-007 signed_mode  input  1  1 = treat bin_in as two's complement; captured together with bin_in.
REQ-008 busy  output  1  1 while a conversion is in progress.
REQ-009 done  output  1  one-cycle pulse marking that new digit outputs are valid.
REQ-010 dig_hund  output  4  hundreds BCD digit, or BLANK_CODE; drives display digit in3.
REQ-011 dig_tens  output  4  tens BCD digit, or BLANK_CODE; drives display digit in2.
REQ-012 dig_ones  output  4  ones BCD digit (0-9, never blanked); drives display digit in1.
REQ-013 neg  output  1  1 = the displayed result is negative.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-015 In IDLE with start=1 (edge k), the block SHALL capture the magnitude and sign, clear the iteration counter, and go to SHIFT.
- Unsigned, or signed with bit7=0: magnitude = bin_in, sign = 0.
- Signed with bit7=1: magnitude = (~bin_in + 1) using 8-bit unsigned arithmetic, sign = 1. The value 8'h80 gives magnitude 128.
REQ-016 SHIFT SHALL perform one double-dabble iteration per cycle.
- Before each shift, add 3 to each 4-bit BCD field that is >= 5.
- Shift the 20-bit {BCD, binary} register left by 1.
- Edges k+1 through k+8 carry out exactly 8 iterations; on edge k+8 the FSM goes to DONE.
REQ-017 On edge k+9 the DONE state SHALL register dig_hund, dig_tens, dig_ones and neg, set done=1, and return to IDLE.
- done SHALL be 1 for exactly the single cycle that follows edge k+9.
REQ-018 busy SHALL be 1 exactly when the state is not IDLE, i.e. for the 9 cycles following edge k.
REQ-019 start SHALL be ignored while busy=1; bin_in and signed_mode changes during a conversion SHALL NOT affect the result.
REQ-020 A start asserted in the cycle where done=1 SHALL be accepted, because the FSM is already in IDLE.
REQ-021 Digit outputs and neg SHALL hold their last values between completions, so the display stays stable.
- They change only on the DONE edge or on reset.
REQ-022 With LZ_BLANK=1, blanking SHALL be applied as follows.
- dig_hund = BLANK_CODE when the hundreds digit is 0.
- dig_tens = BLANK_CODE when both the hundreds and tens digits are 0.
- dig_ones SHALL never be blanked.
REQ-023 neg SHALL be 0 when the magnitude is 0.

Reset
REQ-024 While reset=0 the block SHALL force:
- state = IDLE and counter = 0;
- busy = 0 and done = 0;
- neg = 0 and dig_ones = 0;
- dig_tens = dig_hund = BLANK_CODE if LZ_BLANK=1, otherwise 0.
REQ-025 Reset asserted mid-conversion SHALL abort it with no done pulse and no output update.
REQ-026 After reset is released, the block SHALL accept start on the first rising edge.

Verification
REQ-027 Unsigned value 8'd255 with start at edge k -> busy=1 for 9 cycles; done pulses after edge k+9; outputs 2,5,5; neg=0.
REQ-028 signed_mode=1 with bin_in=8'h80 -> outputs 1,2,8 with neg=1; with 8'hFF -> outputs F,F,1 with neg=1 (LZ_BLANK=1).
REQ-029 Unsigned value 8'd7 -> outputs F,F,7 with LZ_BLANK=1 and 0,0,7 with LZ_BLANK=0; value 8'd0 -> F,F,0 with neg=0.
REQ-030 Conversion of 8'd42 followed by start=1 with bin_in=8'd99 at edge k+3 -> the second start is ignored; outputs 4,2 (hundreds blanked to F); exactly one done pulse.
REQ-031 reset=0 applied asynchronously at edge k+5 of a conversion of 8'd200 -> outputs immediately take the reset values; no done pulse; the previous result is lost.
REQ-032 start held high continuously -> back-to-back conversions with a done pulse every 10 cycles; each start is accepted in the done cycle.
